// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Requester port indices (also the encoding of the last-winner flag).
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    // Legal range of strobe-hold cycles per access.
    localparam int ACC_MIN = 1;
    localparam int ACC_MAX = 4;

    // Counter width large enough for ACC_MAX-1.
    localparam int CNT_W = 2;

    // Saturate a requested access length into the legal range.
    function automatic int acc_clamp(input int acc);
        if (acc < ACC_MIN) begin
            return ACC_MIN;
        end else if (acc > ACC_MAX) begin
            return ACC_MAX;
        end else begin
            return acc;
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the port that did not win last
// time takes priority on a tie.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // One-hot pick from the request vector and the last-winner flag.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                if (last_i == P1) begin
                    gnt_o = 2'b01;
                end else begin
                    gnt_o = 2'b10;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port memory with a
// bidirectional data bus. The DONE state doubles as bus turnaround so read
// drive and write drive can never overlap.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH     = 5,
    parameter int DWIDTH     = 8,
    parameter int ACC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [AWIDTH-1:0] r0_addr,
    input  logic [DWIDTH-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DWIDTH-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [AWIDTH-1:0] r1_addr,
    input  logic [DWIDTH-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DWIDTH-1:0] r1_rdata,
    output logic [1:0]        gnt,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    localparam int              ACC_EFF  = acc_clamp(ACC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                owner_q;
    logic                last_q;
    logic [1:0]          gnt_q;
    logic                r0_ack_q;
    logic                r1_ack_q;
    logic [DWIDTH-1:0]   r0_rdata_q;
    logic [DWIDTH-1:0]   r1_rdata_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [AWIDTH-1:0]   mem_addr_q;
    logic [DWIDTH-1:0]   wdata_q;

    logic [1:0]          pick_s;
    logic                sel_we_s;
    logic [AWIDTH-1:0]   sel_addr_s;
    logic [DWIDTH-1:0]   sel_wdata_s;

    rr_arb2 u_rr_arb2 (
        .req_i  ({r1_req, r0_req}),
        .last_i (last_q),
        .gnt_o  (pick_s)
    );

    // Route the picked port's command fields toward the latches.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {AWIDTH{1'b0}};
        sel_wdata_s = {DWIDTH{1'b0}};
        if (pick_s[1]) begin
            sel_we_s    = r1_we;
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
        end else begin
            sel_we_s    = r0_we;
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
        end
    end

    // Access sequencer: grant, strobe hold, read capture and ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            owner_q    <= P0;
            last_q     <= P1;
            gnt_q      <= 2'b00;
            r0_ack_q   <= 1'b0;
            r1_ack_q   <= 1'b0;
            r0_rdata_q <= {DWIDTH{1'b0}};
            r1_rdata_q <= {DWIDTH{1'b0}};
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {AWIDTH{1'b0}};
            wdata_q    <= {DWIDTH{1'b0}};
        end else begin
            r0_ack_q <= 1'b0;
            r1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_s != 2'b00) begin
                        owner_q    <= pick_s[1];
                        gnt_q      <= pick_s;
                        mem_addr_q <= sel_addr_s;
                        wdata_q    <= sel_wdata_s;
                        cnt_q      <= CNT_INIT;
                        if (sel_we_s) begin
                            state_q  <= WRITE;
                            mem_wr_q <= 1'b1;
                        end else begin
                            state_q  <= READ;
                            mem_rd_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    if (cnt_q == CNT_ZERO) begin
                        if (owner_q == P1) begin
                            r1_rdata_q <= mem_data;
                            r1_ack_q   <= 1'b1;
                        end else begin
                            r0_rdata_q <= mem_data;
                            r0_ack_q   <= 1'b1;
                        end
                        mem_rd_q <= 1'b0;
                        gnt_q    <= 2'b00;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                WRITE: begin
                    if (cnt_q == CNT_ZERO) begin
                        if (owner_q == P1) begin
                            r1_ack_q <= 1'b1;
                        end else begin
                            r0_ack_q <= 1'b1;
                        end
                        mem_wr_q <= 1'b0;
                        gnt_q    <= 2'b00;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DONE: begin
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: begin
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    gnt_q    <= 2'b00;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign mem_data = mem_wr_q ? wdata_q : {DWIDTH{1'bz}};
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign gnt      = gnt_q;
    assign r0_ack   = r0_ack_q;
    assign r1_ack   = r1_ack_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table on an ACC_CYCLES=1 instance,
// plus hand sequences on ACC_CYCLES=2 (reset mid-write) and ACC_CYCLES=3.
module tb_mem_arbiter;

    localparam logic [7:0] PROBE = 8'h96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic mem_clr = 1'b1;

    // ---------------- instance A: ACC_CYCLES=1 ----------------
    logic rst_a, r0_req_a, r0_we_a, r1_req_a, r1_we_a;
    logic [4:0] r0_addr_a, r1_addr_a, mem_addr_a;
    logic [7:0] r0_wdata_a, r1_wdata_a, r0_rdata_a, r1_rdata_a;
    logic r0_ack_a, r1_ack_a, mem_wr_a, mem_rd_a;
    logic [1:0] gnt_a;
    logic [7:0] mem_a [32];
    wire  [7:0] bus_a;
    assign bus_a = (!mem_wr_a) ? (mem_rd_a ? mem_a[mem_addr_a] : PROBE) : 8'hzz;

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .ACC_CYCLES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_a),
        .r0_req(r0_req_a), .r0_we(r0_we_a), .r0_addr(r0_addr_a), .r0_wdata(r0_wdata_a),
        .r0_ack(r0_ack_a), .r0_rdata(r0_rdata_a),
        .r1_req(r1_req_a), .r1_we(r1_we_a), .r1_addr(r1_addr_a), .r1_wdata(r1_wdata_a),
        .r1_ack(r1_ack_a), .r1_rdata(r1_rdata_a),
        .gnt(gnt_a), .mem_wr(mem_wr_a), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a),
        .mem_data(bus_a)
    );

    // ---------------- instance B: ACC_CYCLES=2 ----------------
    logic rst_b, r0_req_b, r0_we_b, r1_req_b, r1_we_b;
    logic [4:0] r0_addr_b, r1_addr_b, mem_addr_b;
    logic [7:0] r0_wdata_b, r1_wdata_b, r0_rdata_b, r1_rdata_b;
    logic r0_ack_b, r1_ack_b, mem_wr_b, mem_rd_b;
    logic [1:0] gnt_b;
    logic [7:0] mem_b [32];
    wire  [7:0] bus_b;
    assign bus_b = (!mem_wr_b) ? (mem_rd_b ? mem_b[mem_addr_b] : PROBE) : 8'hzz;

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .ACC_CYCLES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_b),
        .r0_req(r0_req_b), .r0_we(r0_we_b), .r0_addr(r0_addr_b), .r0_wdata(r0_wdata_b),
        .r0_ack(r0_ack_b), .r0_rdata(r0_rdata_b),
        .r1_req(r1_req_b), .r1_we(r1_we_b), .r1_addr(r1_addr_b), .r1_wdata(r1_wdata_b),
        .r1_ack(r1_ack_b), .r1_rdata(r1_rdata_b),
        .gnt(gnt_b), .mem_wr(mem_wr_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b),
        .mem_data(bus_b)
    );

    // ---------------- instance C: ACC_CYCLES=3 ----------------
    logic rst_c, r0_req_c, r0_we_c, r1_req_c, r1_we_c;
    logic [4:0] r0_addr_c, r1_addr_c, mem_addr_c;
    logic [7:0] r0_wdata_c, r1_wdata_c, r0_rdata_c, r1_rdata_c;
    logic r0_ack_c, r1_ack_c, mem_wr_c, mem_rd_c;
    logic [1:0] gnt_c;
    logic [7:0] mem_c [32];
    wire  [7:0] bus_c;
    assign bus_c = (!mem_wr_c) ? (mem_rd_c ? mem_c[mem_addr_c] : PROBE) : 8'hzz;

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .ACC_CYCLES(3)) u_dut_c (
        .clk(clk), .rst_n(rst_c),
        .r0_req(r0_req_c), .r0_we(r0_we_c), .r0_addr(r0_addr_c), .r0_wdata(r0_wdata_c),
        .r0_ack(r0_ack_c), .r0_rdata(r0_rdata_c),
        .r1_req(r1_req_c), .r1_we(r1_we_c), .r1_addr(r1_addr_c), .r1_wdata(r1_wdata_c),
        .r1_ack(r1_ack_c), .r1_rdata(r1_rdata_c),
        .gnt(gnt_c), .mem_wr(mem_wr_c), .mem_rd(mem_rd_c), .mem_addr(mem_addr_c),
        .mem_data(bus_c)
    );

    // Memory models: write on every edge with the write strobe high.
    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (mem_clr) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
                mem_c[i] <= 8'h00;
            end
        end
        if (!mem_clr && mem_wr_a) mem_a[mem_addr_a] <= bus_a;
        if (!mem_clr && mem_wr_b) mem_b[mem_addr_b] <= bus_b;
        if (!mem_clr && mem_wr_c) mem_c[mem_addr_c] <= bus_c;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus rules: strobes exclusive; idle bus carries only the bench probe
    // (so any controller drive corrupts it); a read sees exactly the memory.
    task automatic bus_chk(input string name, input logic rd, input logic wr,
                           input logic [7:0] bus, input logic [7:0] memv);
        checks++;
        if (rd && wr) begin
            errors++;
            $display("FAIL %s both strobes high", name);
        end else if (!rd && !wr && bus !== PROBE) begin
            errors++;
            $display("FAIL %s idle bus actual=%h required=%h", name, bus, PROBE);
        end else if (rd && bus !== memv) begin
            errors++;
            $display("FAIL %s read bus actual=%h required=%h", name, bus, memv);
        end
    endtask

    always @(negedge clk) if (!mem_clr) bus_chk("bus_a", mem_rd_a, mem_wr_a, bus_a, mem_a[mem_addr_a]);
    always @(negedge clk) if (!mem_clr) bus_chk("bus_b", mem_rd_b, mem_wr_b, bus_b, mem_b[mem_addr_b]);
    always @(negedge clk) if (!mem_clr) bus_chk("bus_c", mem_rd_c, mem_wr_c, bus_c, mem_c[mem_addr_c]);

    typedef struct {
        logic       r0q, r0w;
        logic [4:0] r0a;
        logic [7:0] r0d;
        logic       r1q, r1w;
        logic [4:0] r1a;
        logic [7:0] r1d;
        logic [1:0] gnt;
        logic       rd, wr;
        logic [4:0] addr;
        logic [7:0] data;
        logic       a0, a1;
        logic [7:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(
        input logic r0q, input logic r0w, input logic [4:0] r0a, input logic [7:0] r0d,
        input logic r1q, input logic r1w, input logic [4:0] r1a, input logic [7:0] r1d,
        input logic [1:0] gnt, input logic rd, input logic wr, input logic [4:0] addr,
        input logic [7:0] data, input logic a0, input logic a1,
        input logic [7:0] rd0, input logic [7:0] rd1);
        vec_t v;
        v.r0q = r0q; v.r0w = r0w; v.r0a = r0a; v.r0d = r0d;
        v.r1q = r1q; v.r1w = r1w; v.r1a = r1a; v.r1d = r1d;
        v.gnt = gnt; v.rd = rd; v.wr = wr; v.addr = addr; v.data = data;
        v.a0 = a0; v.a1 = a1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    vec_t vecs [30];

    initial begin
        int ack_at, rd_cnt, wr_cnt;
        logic seen;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        r0_req_a = 1'b0; r0_we_a = 1'b0; r0_addr_a = 5'h00; r0_wdata_a = 8'h00;
        r1_req_a = 1'b0; r1_we_a = 1'b0; r1_addr_a = 5'h00; r1_wdata_a = 8'h00;
        r0_req_b = 1'b0; r0_we_b = 1'b0; r0_addr_b = 5'h00; r0_wdata_b = 8'h00;
        r1_req_b = 1'b0; r1_we_b = 1'b0; r1_addr_b = 5'h00; r1_wdata_b = 8'h00;
        r0_req_c = 1'b0; r0_we_c = 1'b0; r0_addr_c = 5'h00; r0_wdata_c = 8'h00;
        r1_req_c = 1'b0; r1_we_c = 1'b0; r1_addr_c = 5'h00; r1_wdata_c = 8'h00;

        // Cycle table for instance A: each row drives inputs before an edge
        // and lists the outputs expected just after that edge.
        //            r0: q  we   addr   wdata  r1: q  we   addr   wdata   gnt   rd    wr    addr   data   a0    a1    rdata0 rdata1
        vecs[0]  = mk(1'b1,1'b1,5'h01,8'h11, 1'b1,1'b1,5'h02,8'h22, 2'b01,1'b0,1'b1,5'h01,8'h11,1'b0,1'b0,8'h00,8'h00);
        vecs[1]  = mk(1'b1,1'b1,5'h01,8'h11, 1'b1,1'b1,5'h02,8'h22, 2'b00,1'b0,1'b0,5'h01,8'h00,1'b1,1'b0,8'h00,8'h00);
        vecs[2]  = mk(1'b0,1'b0,5'h00,8'h00, 1'b1,1'b1,5'h02,8'h22, 2'b00,1'b0,1'b0,5'h01,8'h00,1'b0,1'b0,8'h00,8'h00);
        vecs[3]  = mk(1'b0,1'b0,5'h00,8'h00, 1'b1,1'b1,5'h02,8'h22, 2'b10,1'b0,1'b1,5'h02,8'h22,1'b0,1'b0,8'h00,8'h00);
        vecs[4]  = mk(1'b0,1'b0,5'h00,8'h00, 1'b1,1'b1,5'h02,8'h22, 2'b00,1'b0,1'b0,5'h02,8'h00,1'b0,1'b1,8'h00,8'h00);
        vecs[5]  = mk(1'b1,1'b1,5'h03,8'hA5, 1'b1,1'b0,5'h02,8'h00, 2'b00,1'b0,1'b0,5'h02,8'h00,1'b0,1'b0,8'h00,8'h00);
        vecs[6]  = mk(1'b1,1'b1,5'h03,8'hA5, 1'b1,1'b0,5'h02,8'h00, 2'b01,1'b0,1'b1,5'h03,8'hA5,1'b0,1'b0,8'h00,8'h00);
        vecs[7]  = mk(1'b1,1'b1,5'h03,8'hA5, 1'b1,1'b0,5'h02,8'h00, 2'b00,1'b0,1'b0,5'h03,8'h00,1'b1,1'b0,8'h00,8'h00);
        vecs[8]  = mk(1'b1,1'b0,5'h03,8'h00, 1'b1,1'b0,5'h02,8'h00, 2'b00,1'b0,1'b0,5'h03,8'h00,1'b0,1'b0,8'h00,8'h00);
        vecs[9]  = mk(1'b1,1'b0,5'h03,8'h00, 1'b1,1'b0,5'h02,8'h00, 2'b10,1'b1,1'b0,5'h02,8'h00,1'b0,1'b0,8'h00,8'h00);
        vecs[10] = mk(1'b1,1'b0,5'h03,8'h00, 1'b1,1'b0,5'h02,8'h00, 2'b00,1'b0,1'b0,5'h02,8'h00,1'b0,1'b1,8'h00,8'h22);
        vecs[11] = mk(1'b1,1'b0,5'h03,8'h00, 1'b1,1'b1,5'h1F,8'h3C, 2'b00,1'b0,1'b0,5'h02,8'h00,1'b0,1'b0,8'h00,8'h22);
        vecs[12] = mk(1'b1,1'b0,5'h03,8'h00, 1'b1,1'b1,5'h1F,8'h3C, 2'b01,1'b1,1'b0,5'h03,8'h00,1'b0,1'b0,8'h00,8'h22);
        vecs[13] = mk(1'b1,1'b0,5'h03,8'h00, 1'b1,1'b1,5'h1F,8'h3C, 2'b00,1'b0,1'b0,5'h03,8'h00,1'b1,1'b0,8'hA5,8'h22);
        vecs[14] = mk(1'b0,1'b0,5'h00,8'h00, 1'b1,1'b1,5'h1F,8'h3C, 2'b00,1'b0,1'b0,5'h03,8'h00,1'b0,1'b0,8'hA5,8'h22);
        vecs[15] = mk(1'b0,1'b0,5'h00,8'h00, 1'b1,1'b1,5'h1F,8'h3C, 2'b10,1'b0,1'b1,5'h1F,8'h3C,1'b0,1'b0,8'hA5,8'h22);
        vecs[16] = mk(1'b0,1'b0,5'h00,8'h00, 1'b1,1'b1,5'h1F,8'h3C, 2'b00,1'b0,1'b0,5'h1F,8'h00,1'b0,1'b1,8'hA5,8'h22);
        vecs[17] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b00,1'b0,1'b0,5'h1F,8'h00,1'b0,1'b0,8'hA5,8'h22);
        vecs[18] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b01,1'b1,1'b0,5'h00,8'h00,1'b0,1'b0,8'hA5,8'h22);
        vecs[19] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b00,1'b0,1'b0,5'h00,8'h00,1'b1,1'b0,8'h00,8'h22);
        vecs[20] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b00,1'b0,1'b0,5'h00,8'h00,1'b0,1'b0,8'h00,8'h22);
        vecs[21] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b10,1'b1,1'b0,5'h1F,8'h00,1'b0,1'b0,8'h00,8'h22);
        vecs[22] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b00,1'b0,1'b0,5'h1F,8'h00,1'b0,1'b1,8'h00,8'h3C);
        vecs[23] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b00,1'b0,1'b0,5'h1F,8'h00,1'b0,1'b0,8'h00,8'h3C);
        vecs[24] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b01,1'b1,1'b0,5'h00,8'h00,1'b0,1'b0,8'h00,8'h3C);
        vecs[25] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b00,1'b0,1'b0,5'h00,8'h00,1'b1,1'b0,8'h00,8'h3C);
        vecs[26] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b00,1'b0,1'b0,5'h00,8'h00,1'b0,1'b0,8'h00,8'h3C);
        vecs[27] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b10,1'b1,1'b0,5'h1F,8'h00,1'b0,1'b0,8'h00,8'h3C);
        vecs[28] = mk(1'b1,1'b0,5'h00,8'h00, 1'b1,1'b0,5'h1F,8'h00, 2'b00,1'b0,1'b0,5'h1F,8'h00,1'b0,1'b1,8'h00,8'h3C);
        vecs[29] = mk(1'b0,1'b0,5'h00,8'h00, 1'b0,1'b0,5'h00,8'h00, 2'b00,1'b0,1'b0,5'h1F,8'h00,1'b0,1'b0,8'h00,8'h3C);

        // Reset state of all three instances.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 64'({gnt_a, mem_rd_a, mem_wr_a, mem_addr_a, r0_ack_a, r1_ack_a, r0_rdata_a, r1_rdata_a}), 64'd0);
        chk("rst_b", 64'({gnt_b, mem_rd_b, mem_wr_b, mem_addr_b, r0_ack_b, r1_ack_b, r0_rdata_b, r1_rdata_b}), 64'd0);
        chk("rst_c", 64'({gnt_c, mem_rd_c, mem_wr_c, mem_addr_c, r0_ack_c, r1_ack_c, r0_rdata_c, r1_rdata_c}), 64'd0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; mem_clr = 1'b0;

        // Table-driven run on instance A.
        for (int i = 0; i < 30; i++) begin
            r0_req_a = vecs[i].r0q; r0_we_a = vecs[i].r0w; r0_addr_a = vecs[i].r0a; r0_wdata_a = vecs[i].r0d;
            r1_req_a = vecs[i].r1q; r1_we_a = vecs[i].r1w; r1_addr_a = vecs[i].r1a; r1_wdata_a = vecs[i].r1d;
            @(posedge clk);
            #1;
            checks++;
            if ({gnt_a, mem_rd_a, mem_wr_a, mem_addr_a, r0_ack_a, r1_ack_a, r0_rdata_a, r1_rdata_a} !==
                {vecs[i].gnt, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].a0, vecs[i].a1, vecs[i].rd0, vecs[i].rd1}) begin
                errors++;
                $display("FAIL vec%0d actual gnt=%b rd=%b wr=%b addr=%h ack=%b%b rdata=%h/%h required gnt=%b rd=%b wr=%b addr=%h ack=%b%b rdata=%h/%h",
                         i, gnt_a, mem_rd_a, mem_wr_a, mem_addr_a, r0_ack_a, r1_ack_a, r0_rdata_a, r1_rdata_a,
                         vecs[i].gnt, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].a0, vecs[i].a1, vecs[i].rd0, vecs[i].rd1);
            end
            if (vecs[i].wr) chk($sformatf("vec%0d_wdata", i), 64'(bus_a), 64'(vecs[i].data));
        end

        // Instance B: reset pulse inside a two-cycle write before any write edge.
        r0_req_b = 1'b1; r0_we_b = 1'b1; r0_addr_b = 5'h04; r0_wdata_b = 8'hFF;
        @(posedge clk);
        #1;
        chk("b_write_on", 64'({gnt_b, mem_wr_b, mem_addr_b, bus_b}), 64'({2'b01, 1'b1, 5'h04, 8'hFF}));
        #2;
        rst_b = 1'b0;
        #1;
        chk("b_rst_abort", 64'({gnt_b, mem_rd_b, mem_wr_b, mem_addr_b, r0_ack_b, r1_ack_b, r0_rdata_b, r1_rdata_b}), 64'd0);
        r0_req_b = 1'b0; r0_we_b = 1'b0; r0_addr_b = 5'h00; r0_wdata_b = 8'h00;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (r0_ack_b || r1_ack_b) seen = 1'b1;
        end
        chk("b_no_ack", 64'(seen), 64'd0);
        chk("b_mem04_kept", 64'(mem_b[4]), 64'h00);
        r0_req_b = 1'b1; r0_we_b = 1'b0; r0_addr_b = 5'h04;
        ack_at = 0; rd_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (mem_rd_b) rd_cnt++;
            if (r0_ack_b) begin
                ack_at = k;
                break;
            end
        end
        r0_req_b = 1'b0;
        chk("b_rd_ack_at", 64'(ack_at), 64'd3);
        chk("b_rd_cycles", 64'(rd_cnt), 64'd2);
        chk("b_rd_data", 64'(r0_rdata_b), 64'h00);

        // Instance C: r1 writes 7E to 1F, then reads it back.
        r1_req_c = 1'b1; r1_we_c = 1'b1; r1_addr_c = 5'h1F; r1_wdata_c = 8'h7E;
        ack_at = 0; wr_cnt = 0; seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (mem_wr_c) wr_cnt++;
            if (r0_ack_c) seen = 1'b1;
            if (r1_ack_c) begin
                ack_at = k;
                break;
            end
        end
        r1_req_c = 1'b0; r1_we_c = 1'b0; r1_wdata_c = 8'h00;
        chk("c_wr_ack_at", 64'(ack_at), 64'd4);
        chk("c_wr_cycles", 64'(wr_cnt), 64'd3);
        @(posedge clk);
        #1;
        chk("c_ack_one_cycle", 64'(r1_ack_c), 64'd0);
        r1_req_c = 1'b1; r1_addr_c = 5'h1F;
        ack_at = 0; rd_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (mem_rd_c) rd_cnt++;
            if (r0_ack_c) seen = 1'b1;
            if (r1_ack_c) begin
                ack_at = k;
                break;
            end
        end
        r1_req_c = 1'b0;
        chk("c_rd_ack_at", 64'(ack_at), 64'd4);
        chk("c_rd_cycles", 64'(rd_cnt), 64'd3);
        chk("c_rd_data", 64'(r1_rdata_c), 64'h7E);
        chk("c_r0_quiet", 64'({seen, r0_rdata_c}), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and access sequencer for the shared single-port memory with bidirectional data bus. Typical requesters are the CPU (port 0) and the program loader/debug port (port 1). It serialises their requests and drives the memory's wr/rd/addr pins. It is the only driver of the memory data bus on the controller side and guarantees that rd-drive and write-drive never overlap.

Parameters:
AWIDTH, 5, memory address width
DWIDTH, 8, memory data width
ACC_CYCLES, 1, cycles mem_rd/mem_wr held per access (1..4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
r0_req  input  1  port 0 request, held until r0_ack
r0_we  input  1  port 0 write (1) / read (0)
r0_addr  input  AWIDTH  port 0 address
r0_wdata  input  DWIDTH  port 0 write data
r0_ack  output  1  port 0 one-cycle completion pulse
r0_rdata  output  DWIDTH  port 0 read data, valid while r0_ack high, held after
r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata  as port 0, for port 1
gnt  output  2  one-hot owner of the current access, 0 when idle
mem_wr  output  1  memory write strobe
mem_rd  output  1  memory read enable
mem_addr  output  AWIDTH  memory address
mem_data  inout  DWIDTH  memory data bus, driven only in WRITE, else high-Z

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_wr=0, mem_rd=0, mem_addr=0, mem_data=Z; gnt=0; r0_ack=r1_ack=0; r0_rdata=r1_rdata=0; last-winner=port 1, so port 0 wins the first tie.
- Reset mid-access aborts immediately. A write whose strobe edge has not occurred is not performed. No ack is issued.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: at each edge, sample r0_req/r1_req.
  - One request: grant it.
  - Both requests: grant the port that is not last-winner (round robin).
  - On grant, latch addr, we and wdata into internal registers. Set gnt. Load the counter with ACC_CYCLES-1. Go to READ (we=0) or WRITE (we=1).
  - No request: stay.
- READ: mem_rd=1; mem_addr=latched address; mem_data not driven. On the edge where the counter is 0, capture mem_data into the granted port's rdata and go to DONE. Otherwise decrement the counter.
- WRITE: mem_wr=1; mem_data=latched wdata; mem_addr=latched address. The memory writes on every edge inside WRITE, with the same value each time. On the edge where the counter is 0, go to DONE.
- DONE:
  - mem_rd=0, mem_wr=0, mem_data=Z. This state is the bus turnaround.
  - Granted port's ack=1 for exactly this cycle; gnt cleared. Update last-winner. Next state IDLE.
- Latency: request sampled at edge E0 -> ack high in the cycle after edge E0+ACC_CYCLES. Access period is ACC_CYCLES+2 cycles.
- Requester rule: drop req, or present a new request, in the ack cycle. A req still high at the next IDLE edge is a new request.
- Invariants:
  - mem_rd and mem_wr are never both 1.
  - mem_data is never driven while mem_rd=1.
  - At least one cycle with neither strobe separates consecutive accesses.
  - Ungranted ports see ack=0, and their rdata is unchanged.
- Input changes to addr/wdata/we after the grant edge do not affect the in-flight access.
- mem_addr holds its last value in IDLE/DONE.

Decomposition:
- Package mem_arb_pkg holds the state enum (IDLE, READ, WRITE, DONE), port index constants P0=0 and P1=1, and the ACC_CYCLES legal range.
- One sub-module, rr_arb2: combinational 2-way round-robin pick from req[1:0] and last-winner, returning one-hot grant. The FSM, counter, latches and tri-state stay in mem_arbiter.

Test Plan:
- Write then read, ACC_CYCLES=1: r0 writes 8'hA5 to addr 5'h03; r0 then reads 5'h03 -> mem_wr high exactly 1 cycle with mem_data=A5; r0_ack after 2 cycles; read returns r0_rdata=8'hA5; r1_ack stays 0.
- Simultaneous requests from reset: r0 writes 8'h11 @5'h01 and r1 writes 8'h22 @5'h02 in the same cycle -> r0 served first. r1 is served starting the cycle after r0_ack. A following tie goes to r0 again (alternation).
- Both ports hold req continuously (reads, addr 5'h00 and 5'h1F) -> grants alternate r0,r1,r0,r1. Each ack is spaced ACC_CYCLES+2 cycles apart.
- ACC_CYCLES=3, r1 reads 5'h1F preloaded with 8'h7E -> mem_rd high exactly 3 cycles; r1_ack in 4th cycle after grant edge; r1_rdata=8'h7E.
- rst_n pulsed low during WRITE with ACC_CYCLES=2 (8'hFF @5'h04, location holds 8'h00), asserted before the final strobe edge -> outputs return to reset values immediately; no ack; a subsequent read of 5'h04 returns 8'h00.
- Bus checker throughout all tests:
  - mem_data is Z whenever state is not WRITE.
  - mem_rd and mem_wr are never both 1.
  - No X on mem_data while mem_rd=1.
